// File: rtl/fc_layer_engine.sv
// Time-multiplexed fully-connected layer: LANES MAC lanes sweep N_OUT neurons group by group,
// streaming inputs/weights from one-cycle-latency memories and writing one result per cycle.
module fc_layer_engine #(
    parameter int unsigned DW    = 16,
    parameter int unsigned FRAC  = 8,
    parameter int unsigned N_IN  = 784,
    parameter int unsigned N_OUT = 128,
    parameter int unsigned LANES = 8,
    parameter int unsigned ACC_W = 40
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  start,
    input  logic                                                  relu_en,
    output logic                                                  busy,
    output logic                                                  done,
    output logic [$clog2(N_IN)-1:0]                               in_addr,
    input  logic [DW-1:0]                                         in_data,
    output logic [$clog2(((N_OUT+LANES-1)/LANES)*N_IN)-1:0]       w_addr,
    input  logic [LANES*DW-1:0]                                   w_data,
    output logic                                                  out_valid,
    output logic [$clog2(N_OUT)-1:0]                              out_addr,
    output logic [DW-1:0]                                         out_data
);

    localparam int unsigned G      = (N_OUT + LANES - 1) / LANES;
    localparam int unsigned IN_AW  = $clog2(N_IN);
    localparam int unsigned G_W    = (G > 1) ? $clog2(G) : 1;
    localparam int unsigned L_W    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned N_LAST = N_OUT - (G - 1) * LANES;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_MAC   = 3'd1;
    localparam logic [2:0] S_FLUSH = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]              state_q;
    logic [G_W-1:0]          g_q;
    logic [L_W-1:0]          lane_q;
    logic                    relu_q;
    logic signed [ACC_W-1:0] acc_q [LANES];
    logic signed [ACC_W-1:0] acc_d [LANES];
    logic signed [2*DW-1:0]  prod  [LANES];

    logic           data_vld;
    logic           data_first;
    logic           last_group;
    logic [L_W-1:0] lane_end;
    logic [L_W-1:0] drain_sel;
    logic [DW-1:0]  drain_data;

    // Arithmetic shift floors; saturate when the bits above the result's sign are not uniform.
    function automatic logic [DW-1:0] rescale(input logic signed [ACC_W-1:0] a,
                                              input logic relu);
        logic signed [ACC_W-1:0] sh;
        logic [DW-1:0]           r;
        sh = a >>> FRAC;
        if (sh[ACC_W-1:DW-1] == '0 || sh[ACC_W-1:DW-1] == '1) begin
            r = sh[DW-1:0];
        end else if (sh[ACC_W-1]) begin
            r = {1'b1, {(DW-1){1'b0}}};
        end else begin
            r = {1'b0, {(DW-1){1'b1}}};
        end
        if (relu && r[DW-1]) begin
            r = '0;
        end
        return r;
    endfunction

    // Memory data lags the address by one cycle, so index i is consumed while i+1 is driven.
    always_comb begin
        data_vld   = (state_q == S_MAC && in_addr != '0) || state_q == S_FLUSH;
        data_first = state_q == S_MAC && in_addr == IN_AW'(1);
        for (int l = 0; l < LANES; l++) begin
            prod[l]  = $signed(in_data) * $signed(w_data[l*DW +: DW]);
            acc_d[l] = acc_q[l];
            if (data_vld) begin
                acc_d[l] = data_first ? ACC_W'(prod[l]) : acc_q[l] + ACC_W'(prod[l]);
            end
        end
    end

    always_comb begin
        last_group = g_q == G_W'(G - 1);
        lane_end   = last_group ? L_W'(N_LAST - 1) : L_W'(LANES - 1);
        drain_sel  = (state_q == S_FLUSH) ? '0 : lane_q + 1'b1;
        drain_data = rescale(acc_d[drain_sel], relu_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            g_q       <= '0;
            lane_q    <= '0;
            relu_q    <= 1'b0;
            acc_q     <= '{default: '0};
            busy      <= 1'b0;
            done      <= 1'b0;
            in_addr   <= '0;
            w_addr    <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else begin
            done  <= 1'b0;
            acc_q <= acc_d;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_MAC;
                        busy    <= 1'b1;
                        relu_q  <= relu_en;
                        g_q     <= '0;
                        in_addr <= '0;
                        w_addr  <= '0;
                    end
                end
                S_MAC: begin
                    if (in_addr == IN_AW'(N_IN - 1)) begin
                        state_q <= S_FLUSH;
                    end else begin
                        in_addr <= in_addr + 1'b1;
                        w_addr  <= w_addr + 1'b1;
                    end
                end
                S_FLUSH: begin
                    state_q   <= S_DRAIN;
                    lane_q    <= '0;
                    out_valid <= 1'b1;
                    out_addr  <= (g_q == '0) ? '0 : out_addr + 1'b1;
                    out_data  <= drain_data;
                end
                S_DRAIN: begin
                    if (lane_q == lane_end) begin
                        out_valid <= 1'b0;
                        if (last_group) begin
                            state_q <= S_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            state_q <= S_MAC;
                            g_q     <= g_q + 1'b1;
                            in_addr <= '0;
                            // (g+1)*N_IN directly follows g*N_IN + N_IN-1
                            w_addr  <= w_addr + 1'b1;
                        end
                    end else begin
                        lane_q   <= lane_q + 1'b1;
                        out_addr <= out_addr + 1'b1;
                        out_data <= drain_data;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_layer_engine.sv
// Directed and randomized checks of fc_layer_engine (N_IN=4, N_OUT=3, LANES=2) against a
// plain-arithmetic dot-product model.
module tb_fc_layer_engine;

    localparam int DW    = 16;
    localparam int N_IN  = 4;
    localparam int N_OUT = 3;
    localparam int LANES = 2;
    localparam int G     = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        relu_en;
    logic        busy;
    logic        done;
    logic [1:0]  in_addr;
    logic [15:0] in_data;
    logic [2:0]  w_addr;
    logic [31:0] w_data;
    logic        out_valid;
    logic [1:0]  out_addr;
    logic [15:0] out_data;

    logic signed [15:0] in_mem [N_IN];
    logic signed [15:0] wl [G*LANES][N_IN];  // wl[neuron][i]

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fc_layer_engine #(
        .DW(16), .FRAC(8), .N_IN(N_IN), .N_OUT(N_OUT), .LANES(LANES), .ACC_W(40)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .relu_en(relu_en), .busy(busy), .done(done),
        .in_addr(in_addr), .in_data(in_data), .w_addr(w_addr), .w_data(w_data),
        .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data)
    );

    // Synchronous memories with one cycle of read latency.
    always @(posedge clk) begin
        in_data <= in_mem[in_addr];
        for (int l = 0; l < LANES; l++) begin
            w_data[l*DW +: DW] <= wl[(int'(w_addr) / N_IN) * LANES + l][int'(w_addr) % N_IN];
        end
    end

    function automatic logic [15:0] expect_out(input int k, input bit relu);
        longint acc;
        acc = 0;
        for (int i = 0; i < N_IN; i++) acc += longint'(in_mem[i]) * longint'(wl[k][i]);
        acc = acc >>> 8;
        if (acc > 32767) acc = 32767;
        else if (acc < -32768) acc = -32768;
        if (relu && acc < 0) acc = 0;
        return 16'(acc);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_all(input logic [15:0] iv, input logic [15:0] wv);
        for (int i = 0; i < N_IN; i++) begin
            in_mem[i] = iv;
            for (int n = 0; n < G*LANES; n++) wl[n][i] = wv;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
        check({tag, " out_valid"}, out_valid, 0);
        check({tag, " out_addr"}, out_addr, 0);
        check({tag, " out_data"}, out_data, 0);
        check({tag, " in_addr"}, in_addr, 0);
        check({tag, " w_addr"}, w_addr, 0);
    endtask

    // One layer evaluation, observed cycle by cycle over a fixed window.
    task automatic run_check(input string tag, input bit relu, input int restart_at,
                             input bit start_in_done);
        int busy_cnt, done_cnt, done_cyc, last_ov, n;
        int ia[$], wa[$], oa[$], od[$], exp_i[$], exp_w[$];
        busy_cnt = 0; done_cnt = 0; done_cyc = -1; last_ov = -1;
        @(negedge clk);
        start = 1'b1; relu_en = relu;
        @(negedge clk);
        start = 1'b0; relu_en = ~relu;
        for (int c = 0; c < 24; c++) begin
            if (c > 0) @(negedge clk);
            start = (c == restart_at) || (start_in_done && done === 1'b1);
            if (busy === 1'b1) begin
                busy_cnt++;
                ia.push_back(int'(in_addr));
                wa.push_back(int'(w_addr));
            end
            if (out_valid === 1'b1) begin
                oa.push_back(int'(out_addr));
                od.push_back(int'(out_data));
                last_ov = c;
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = c;
            end
        end
        start = 1'b0;
        check({tag, " busy cycles"}, busy_cnt, 13);
        check({tag, " done pulses"}, done_cnt, 1);
        check({tag, " done after last write"}, done_cyc, last_ov + 1);
        check({tag, " write count"}, oa.size(), N_OUT);
        for (int k = 0; k < N_OUT && k < oa.size(); k++) begin
            check($sformatf("%s out_addr[%0d]", tag, k), oa[k], k);
            check($sformatf("%s out_data[%0d]", tag, k), od[k], expect_out(k, relu));
        end
        for (int g = 0; g < G; g++) begin
            n = (g == G - 1) ? N_OUT - (G - 1) * LANES : LANES;
            for (int i = 0; i < N_IN; i++) begin
                exp_i.push_back(i);
                exp_w.push_back(g * N_IN + i);
            end
            for (int j = 0; j < 1 + n; j++) begin
                exp_i.push_back(N_IN - 1);
                exp_w.push_back(g * N_IN + N_IN - 1);
            end
        end
        for (int c = 0; c < exp_i.size() && c < ia.size(); c++) begin
            check($sformatf("%s in_addr@%0d", tag, c), ia[c], exp_i[c]);
            check($sformatf("%s w_addr@%0d", tag, c), wa[c], exp_w[c]);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; relu_en = 1'b0;
        set_all(16'd0, 16'd0);
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        set_all(16'd256, 16'd256);
        run_check("basic", 1'b0, -1, 1'b0);

        set_all(16'd256, 16'hFF00);
        run_check("neg no relu", 1'b0, -1, 1'b0);
        run_check("neg relu", 1'b1, -1, 1'b0);

        set_all(16'h7FFF, 16'h7FFF);
        run_check("sat pos", 1'b0, -1, 1'b0);
        set_all(16'h7FFF, 16'h8000);
        run_check("sat neg", 1'b0, -1, 1'b0);

        set_all(16'd0, 16'hFFFF);
        in_mem[0] = 16'sd1;
        run_check("floor", 1'b0, -1, 1'b0);

        set_all(16'd256, 16'd0);
        for (int n = 0; n < G*LANES; n++)
            for (int i = 0; i < N_IN; i++) wl[n][i] = 16'(((n % LANES) + 1) * 256);
        run_check("lanes", 1'b0, -1, 1'b0);

        set_all(16'd256, 16'd256);
        run_check("start busy", 1'b0, 4, 1'b0);
        run_check("start in done", 1'b0, -1, 1'b1);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N_IN; i++) begin
                in_mem[i] = (r < 2) ? 16'($urandom_range(0, 4095) - 2048) : 16'($urandom());
                for (int n = 0; n < G*LANES; n++)
                    wl[n][i] = (r < 2) ? 16'($urandom_range(0, 4095) - 2048) : 16'($urandom());
            end
            run_check($sformatf("random%0d", r), 1'($urandom_range(0, 1)), -1, 1'b0);
        end

        // Reset during the MAC phase of group 1 (busy cycle 9).
        set_all(16'd256, 16'd256);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("midrun busy before reset", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("midrun reset");
        @(negedge clk);
        check("midrun stays idle", busy, 0);
        run_check("after reset", 1'b0, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
